// File: rtl/c64_video_pkg.sv
// Shared constants for the C64 composite video path: palette tables, burst hues and encoder states.
package c64_video_pkg;

    localparam int CNT_W = 10;

    localparam logic [4:0] BURST_HUE_EVEN = 5'd12;
    localparam logic [4:0] BURST_HUE_ODD  = 5'd20;

    typedef enum logic [2:0] {
        ST_SYNC      = 3'd0,
        ST_BREEZEWAY = 3'd1,
        ST_BURST     = 3'd2,
        ST_PORCH     = 3'd3,
        ST_ACTIVE    = 3'd4
    } state_e;

    // Luma is kept at or below 47 so rf_modulator's +16 chroma offset stays within 6 bits.
    localparam logic [5:0] palette_luma [16] = '{
        6'd12, 6'd47, 6'd22, 6'd38, 6'd25, 6'd32, 6'd18, 6'd42,
        6'd25, 6'd18, 6'd32, 6'd22, 6'd29, 6'd42, 6'd29, 6'd36
    };

    localparam logic [4:0] palette_hue [16] = '{
        5'd0,  5'd0,  5'd4,  5'd20, 5'd1,  5'd26, 5'd14, 5'd30,
        5'd6,  5'd8,  5'd4,  5'd0,  5'd0,  5'd26, 5'd14, 5'd0
    };

    localparam logic palette_chroma_en [16] = '{
        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0
    };

endpackage

// File: rtl/composite_palette.sv
// Combinational palette lookup: C64 colour index to luma level, hue step and chroma enable.
module composite_palette
    import c64_video_pkg::*;
(
    input  logic [3:0] pixel,
    output logic [5:0] luma,
    output logic [4:0] hue,
    output logic       chroma_en
);

    assign luma      = palette_luma[pixel];
    assign hue       = palette_hue[pixel];
    assign chroma_en = palette_chroma_en[pixel];

endmodule

// File: rtl/composite_encoder.sv
// Composite line encoder: sync/blank levels, PAL burst with V-switch, and 1-bit chroma.
//   state        | meaning
//   ST_SYNC      | sync tip, waiting for hsync to fall
//   ST_BREEZEWAY | blank level, counting down to burst start
//   ST_BURST     | blank level plus colour burst, counting down burst length
//   ST_PORCH     | blank level, waiting for blank to drop
//   ST_ACTIVE    | palette luma and chroma
module composite_encoder
    import c64_video_pkg::*;
#(
    parameter int         BREEZEWAY_CYC = 128,
    parameter int         BURST_CYC     = 320,
    parameter logic [5:0] BLANK_LEVEL   = 6'd12,
    parameter logic [5:0] SYNC_LEVEL    = 6'd0
) (
    input  logic       clk_142mhz,
    input  logic       rst,
    input  logic [3:0] pixel,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    output logic [5:0] luma,
    output logic       color,
    output logic       line_odd
);

    localparam logic [CNT_W-1:0] BREEZEWAY_LOAD = CNT_W'(BREEZEWAY_CYC - 1);
    localparam logic [CNT_W-1:0] BURST_LOAD     = CNT_W'(BURST_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       phase_q, phase_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_odd_q, line_odd_d;
    logic [5:0]       luma_q, luma_d;
    logic             color_q, color_d;

    logic       hsync_rise, hsync_fall, vsync_rise;
    logic [5:0] pal_luma;
    logic [4:0] pal_hue;
    logic       pal_chroma_en;
    logic [4:0] hue_eff, chroma_sum, burst_sum;

    composite_palette u_palette (
        .pixel     (pixel),
        .luma      (pal_luma),
        .hue       (pal_hue),
        .chroma_en (pal_chroma_en)
    );

    always_comb begin
        hsync_rise = hsync & ~hsync_q;
        hsync_fall = ~hsync & hsync_q;
        vsync_rise = vsync & ~vsync_q;
        hsync_d    = hsync;
        vsync_d    = vsync;
        phase_d    = phase_q + 5'd1;
        line_odd_d = line_odd_q;
        // Frame alignment wins over the per-line toggle.
        if (vsync_rise) begin
            line_odd_d = 1'b0;
        end else if (hsync_rise) begin
            line_odd_d = ~line_odd_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hsync_rise) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_SYNC: begin
                    if (hsync_fall) begin
                        state_d = ST_BREEZEWAY;
                        cnt_d   = BREEZEWAY_LOAD;
                    end
                end
                ST_BREEZEWAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_BURST;
                        cnt_d   = BURST_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_BURST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PORCH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_PORCH: begin
                    if (!blank) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (blank) state_d = ST_PORCH;
                end
                default: state_d = ST_PORCH;
            endcase
        end
    end

    always_comb begin
        // Odd lines run the chroma phase backwards: (32 - hue) mod 32.
        hue_eff    = line_odd_q ? (5'd0 - pal_hue) : pal_hue;
        chroma_sum = phase_q + hue_eff;
        burst_sum  = phase_q + (line_odd_q ? BURST_HUE_ODD : BURST_HUE_EVEN);
        luma_d     = BLANK_LEVEL;
        color_d    = 1'b0;
        unique case (state_q)
            ST_SYNC:   luma_d = SYNC_LEVEL;
            ST_BURST:  color_d = burst_sum[4];
            ST_ACTIVE: begin
                luma_d  = pal_luma;
                color_d = pal_chroma_en & chroma_sum[4];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_142mhz) begin
        if (rst) begin
            state_q    <= ST_PORCH;
            cnt_q      <= '0;
            phase_q    <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            line_odd_q <= 1'b0;
            luma_q     <= '0;
            color_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            line_odd_q <= line_odd_d;
            luma_q     <= luma_d;
            color_q    <= color_d;
        end
    end

    assign luma     = luma_q;
    assign color    = color_q;
    assign line_odd = line_odd_q;

endmodule

// File: tb/tb_composite_encoder.sv
// Bench for composite_encoder: randomized line timing and pixels against a cycle-count reference.
module tb_composite_encoder;

    localparam int BW        = 128;
    localparam int BL        = 320;
    localparam int FULL_POST = 1 + BW + BL + 4;

    logic       clk_142mhz = 1'b0;
    logic       rst;
    logic [3:0] pixel;
    logic       hsync, vsync, blank;
    logic [5:0] luma;
    logic       color, line_odd;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [4:0] ph;
    logic exp_odd;

    always #5 clk_142mhz = ~clk_142mhz;

    composite_encoder #(
        .BREEZEWAY_CYC (BW),
        .BURST_CYC     (BL),
        .BLANK_LEVEL   (6'd12),
        .SYNC_LEVEL    (6'd0)
    ) dut (
        .clk_142mhz (clk_142mhz),
        .rst        (rst),
        .pixel      (pixel),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank),
        .luma       (luma),
        .color      (color),
        .line_odd   (line_odd)
    );

    // Carrier phase as seen by the DUT: cycles since the last reset edge, modulo 32.
    always @(posedge clk_142mhz) ph <= rst ? 5'd0 : ph + 5'd1;

    // Output sampled after edge n was computed from the phase held before edge n.
    function automatic logic carrier_bit(input int hue);
        int s;
        s = (int'(ph) + 31 + hue) % 32;
        return (s >= 16);
    endfunction

    function automatic int exp_pix_luma(input int p);
        case (p)
            0: return 12;
            1: return 47;
            2: return 22;
            default: return -1;
        endcase
    endfunction

    function automatic logic exp_pix_color(input int p);
        if (p == 2) return carrier_bit(exp_odd ? 28 : 4);
        return 1'b0;
    endfunction

    task automatic step();
        @(negedge clk_142mhz);
    endtask

    task automatic run_line(input int sync_w, input int post, input bit with_vsync);
        int    el;
        logic  ec;
        string region;
        hsync   = 1'b1;
        blank   = 1'b1;
        vsync   = with_vsync;
        exp_odd = with_vsync ? 1'b0 : ~exp_odd;
        for (int i = 0; i < sync_w; i++) begin
            step();
            n_checks++;
            if (line_odd !== exp_odd) begin
                n_fail++;
                $display("FAIL line_odd sync_cycle=%0d: got %b, expected %b", i, line_odd, exp_odd);
            end
            if (i >= 1) begin
                n_checks++;
                if (luma !== 6'd0 || color !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sync_level cycle=%0d: luma=%0d color=%b, expected luma=0 color=0",
                             i, luma, color);
                end
            end
        end
        hsync = 1'b0;
        vsync = 1'b0;
        for (int j = 0; j < post; j++) begin
            step();
            if (j == 0) begin
                el = 0;  ec = 1'b0; region = "sync_tail";
            end else if (j <= BW) begin
                el = 12; ec = 1'b0; region = "breezeway";
            end else if (j <= BW + BL) begin
                el = 12; ec = carrier_bit(exp_odd ? 20 : 12); region = "burst";
            end else begin
                el = 12; ec = 1'b0; region = "porch";
            end
            n_checks++;
            if (luma !== 6'(el) || color !== ec) begin
                n_fail++;
                $display("FAIL %s j=%0d odd=%b: luma=%0d color=%b, expected luma=%0d color=%b",
                         region, j, exp_odd, luma, color, el, ec);
            end
        end
    endtask

    task automatic run_active(input int n);
        int p;
        blank = 1'b0;
        pixel = 4'd1;
        step();
        n_checks++;
        if (luma !== 6'd12 || color !== 1'b0) begin
            n_fail++;
            $display("FAIL porch_to_active: luma=%0d color=%b, expected luma=12 color=0", luma, color);
        end
        for (int i = 0; i < n; i++) begin
            p = (i < 4) ? 1 : (i < 20) ? 2 : int'($urandom_range(0, 15));
            pixel = 4'(p);
            step();
            n_checks++;
            if (p <= 2) begin
                if (luma !== 6'(exp_pix_luma(p)) || color !== exp_pix_color(p)) begin
                    n_fail++;
                    $display("FAIL active_pixel p=%0d odd=%b: luma=%0d color=%b, expected luma=%0d color=%b",
                             p, exp_odd, luma, color, exp_pix_luma(p), exp_pix_color(p));
                end
            end else if (luma > 6'd47) begin
                n_fail++;
                $display("FAIL luma_range p=%0d: luma=%0d, expected at most 47", p, luma);
            end
        end
        blank = 1'b1;
        step();
        step();
        n_checks++;
        if (luma !== 6'd12 || color !== 1'b0) begin
            n_fail++;
            $display("FAIL active_to_porch: luma=%0d color=%b, expected luma=12 color=0", luma, color);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0; blank = 1'b1; pixel = 4'd0;
        exp_odd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (luma !== 6'd0 || color !== 1'b0 || line_odd !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle=%0d: luma=%0d color=%b line_odd=%b, expected 0/0/0",
                         i, luma, color, line_odd);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (luma !== 6'd12 || color !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_blank cycle=%0d: luma=%0d color=%b, expected luma=12 color=0",
                         i, luma, color);
            end
        end
    endtask

    task automatic test_line_sequence();
        run_line(600, FULL_POST, 1'b0);
    endtask

    task automatic test_active_video();
        run_active(64);
        run_line(int'($urandom_range(30, 100)), FULL_POST, 1'b0);
        run_active(64);
    endtask

    task automatic test_pal_alternation();
        run_line(int'($urandom_range(20, 80)), FULL_POST, 1'b0);
        run_line(int'($urandom_range(20, 80)), FULL_POST, 1'b0);
        if (exp_odd) run_line(40, FULL_POST, 1'b0);
        run_line(40, FULL_POST, 1'b1);
        run_line(40, FULL_POST, 1'b0);
        vsync = 1'b1;
        step();
        exp_odd = 1'b0;
        n_checks++;
        if (line_odd !== 1'b0) begin
            n_fail++;
            $display("FAIL vsync_align: line_odd=%b, expected 0", line_odd);
        end
        vsync = 1'b0;
        step();
    endtask

    task automatic test_interrupted_burst();
        run_line(int'($urandom_range(20, 200)), BW + 1 + int'($urandom_range(10, 300)), 1'b0);
        run_line(int'($urandom_range(20, 200)), FULL_POST, 1'b0);
    endtask

    task automatic test_mid_line_reset();
        run_line(50, FULL_POST, 1'b0);
        blank = 1'b0;
        pixel = 4'd1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (luma !== 6'd0 || color !== 1'b0 || line_odd !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: luma=%0d color=%b line_odd=%b, expected 0/0/0", luma, color, line_odd);
        end
        rst = 1'b0;
        exp_odd = 1'b0;
        step();
        step();
        n_checks++;
        if (luma !== 6'd47 || color !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_active: luma=%0d color=%b, expected luma=47 color=0", luma, color);
        end
        pixel = 4'd2;
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if (luma !== 6'd22 || color !== exp_pix_color(2)) begin
                n_fail++;
                $display("FAIL resume_red i=%0d: luma=%0d color=%b, expected luma=22 color=%b",
                         i, luma, color, exp_pix_color(2));
            end
        end
        blank = 1'b1;
        step();
        step();
        for (int i = 0; i < 600; i++) begin
            step();
            n_checks++;
            if (luma !== 6'd12 || color !== 1'b0) begin
                n_fail++;
                $display("FAIL no_burst_after_reset i=%0d: luma=%0d color=%b, expected luma=12 color=0",
                         i, luma, color);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            run_line(int'($urandom_range(2, 700)), FULL_POST, 1'b0);
            run_active(int'($urandom_range(10, 200)));
        end
    endtask

    initial begin
        test_reset();
        test_line_sequence();
        test_active_video();
        test_pal_alternation();
        test_interrupted_burst();
        test_mid_line_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/composite_encoder.md
# composite_encoder

Converts the VIC-II pixel colour index and sync/blank strobes into the `luma[5:0]` and `color` signals consumed by `rf_modulator`, running in the same `clk_142mhz` domain (32 × colour carrier). It generates:

- sync tip, blanking and black levels;
- PAL colour burst with per-line phase alternation;
- a 1-bit chroma square wave whose phase encodes hue.

All outputs are registered.

## Interface
Parameters:
- `BREEZEWAY_CYC`, default 128: cycles from hsync falling edge to burst start.
- `BURST_CYC`, default 320: burst length in cycles (10 carrier periods).
- `BLANK_LEVEL`, default 12: 6-bit luma during blanking/burst; equals black.
- `SYNC_LEVEL`, default 0: 6-bit luma during sync tip.

Ports (one clock; reset is synchronous and active-high):
- `clk_142mhz`  in  1  colour carrier × 32 (141.8758 MHz)
- `rst`  in  1  synchronous, active-high reset
- `pixel`  in  4  C64 palette index, synchronous to `clk_142mhz`
- `hsync`  in  1  high during horizontal sync pulse
- `vsync`  in  1  high during vertical sync
- `blank`  in  1  high outside the active picture
- `luma`  out  6  luminance to `rf_modulator`
- `color`  out  1  chroma square wave (`rf_modulator` adds 16 when high)
- `line_odd`  out  1  PAL V-switch state for the current line

## Operation
- **Phase counter** `phase[4:0]`: increments every cycle and wraps 31→0.
- **Line toggle**: on each `hsync` rising edge, `line_odd` toggles.
- **Frame alignment**: a `vsync` rising edge forces `line_odd` to 0, overriding a simultaneous hsync toggle.
- **Chroma**:
  - `hue_eff` = `hue` on even lines; `(32 − hue) & 31` on odd lines.
  - `color` = bit 4 of `(phase + hue_eff)`, gated by the chroma enable.
- **Burst**: the burst uses `hue` = 12 (135°) on even lines and 20 (225°) on odd lines.
- **State machine** (one state register):
  - SYNC: entered on an `hsync` rising edge from any state. Outputs `luma`=`SYNC_LEVEL`, `color`=0. On `hsync` falling edge → BREEZEWAY.
  - BREEZEWAY: `luma`=`BLANK_LEVEL`, `color`=0. Counts `BREEZEWAY_CYC` cycles, then → BURST.
  - BURST: `luma`=`BLANK_LEVEL`, `color`=burst square wave. Counts `BURST_CYC` cycles, then → PORCH.
  - PORCH: `luma`=`BLANK_LEVEL`, `color`=0. When `blank`=0 → ACTIVE.
  - ACTIVE: `luma`=`palette_luma[pixel]`, `color`=chroma if `palette_chroma_en[pixel]`, else 0. When `blank`=1 → PORCH.
- **Blanking during timing states**: `blank` is ignored in SYNC, BREEZEWAY and BURST. If `blank` is already low when BURST ends, PORCH exits to ACTIVE on the next cycle.
- **Luma range**: palette luma values are ≤ 47, so `luma` + 16 ≤ 63 and never overflows the 6-bit sum in `rf_modulator`.

## Timing
- **Latency**: 1 cycle. Outputs at edge n reflect inputs, state and phase sampled at edge n−1.
- **Edge detection**: uses a registered copy of `hsync`/`vsync`.
  - An hsync rising edge sampled at cycle k shows `SYNC_LEVEL` on `luma` at k+1.
- **Burst window**: the first burst cycle is exactly `BREEZEWAY_CYC` cycles after the first cycle in BREEZEWAY. The burst lasts exactly `BURST_CYC` cycles.
- **Reset** (`rst`=1 at a clock edge):
  - outputs: `luma`=0, `color`=0, `line_odd`=0;
  - `phase`=0, state=PORCH, counters=0, edge registers=0.
- **Reset mid-line**: abandons the current state. No burst is generated until the next hsync.
- **hsync during BREEZEWAY/BURST**: immediately returns to SYNC and clears the counters.
- **Counter widths**: counters are ≥ 10 bits and saturate; they never wrap inside a state.

## Structure
- Package `c64_video_pkg` holds:
  - `palette_luma[16]` (6-bit), `palette_hue[16]` (5-bit) and `palette_chroma_en[16]`;
  - burst hue constants 12/20;
  - the state enum (SYNC, BREEZEWAY, BURST, PORCH, ACTIVE).
- Required palette entries:
  - 0 black: luma 12, chroma off;
  - 1 white: luma 47, chroma off;
  - 2 red: luma 22, hue 4, chroma on.
- Sub-module `composite_palette`: combinational lookup `pixel` → {luma, hue, chroma_en}. The state machine, phase counter and output registers stay in `composite_encoder`.

## Test plan
- **Reset**: hold `rst` 3 cycles → `luma`=0, `color`=0, `line_odd`=0. After release with no sync, `luma`=12.
- **Line sequence**: `hsync` high 600 cycles, then low, with `blank`=1 → `luma`=0 during sync.
  - Burst starts 128 cycles after the falling edge and `color` toggles every 16 cycles for 320 cycles.
  - `luma` stays 12 throughout.
- **Active video**: `blank`=0 with `pixel`=1 → `luma`=47, `color`=0.
  - `pixel`=2 on an even line → `luma`=22 and `color`=bit4(`phase`+4).
  - On the next line `color`=bit4(`phase`+28).
- **PAL alternation**: two consecutive hsyncs → `line_odd` 1 then 0, and the burst phase offset switches 20 → 12.
  - A `vsync` edge coinciding with an hsync edge → `line_odd`=0.
- **Interrupted burst**: hsync rising mid-burst → SYNC (`luma`=0) on the next cycle and the burst stops. The following line produces a full 320-cycle burst.
- **Mid-line reset**: assert `rst` during ACTIVE → all outputs 0 the next cycle.
  - With `blank`=0 after release → ACTIVE output resumes within 2 cycles. No burst appears before the next hsync.
